// File: rtl/button_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : button_event_ctrl
// Purpose  : Push-button front end. Synchronizes N active-low raw keys,
//            debounces each with its own counter, arbitrates press events
//            (lowest index first) into a small FIFO drained via valid/ready.
// Options  : BTN_REPEAT_EN - when defined, a held button generates auto-repeat
//            events (evt_repeat=1) after REPEAT_DELAY, then every
//            REPEAT_PERIOD cycles. Undefined: no repeat logic, evt_repeat=0.
// Revision : 1.0 - initial release
// ============================================================================
module button_event_ctrl #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CW              = 16,
  parameter int FIFO_DEPTH      = 4,
  parameter int REPEAT_DELAY    = 25000,
  parameter int REPEAT_PERIOD   = 10000
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [N-1:0]         key_n,
  output logic [N-1:0]         pressed,
  output logic                 evt_valid,
  output logic [$clog2(N)-1:0] evt_id,
  output logic                 evt_repeat,
  input  logic                 evt_ready,
  output logic                 evt_lost
);

  localparam int IDW = $clog2(N);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] c_DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW:0]   c_FULL     = (AW+1)'(FIFO_DEPTH);

  // Synchronizer / debounce state
  logic [N-1:0]   r_s1;
  logic [N-1:0]   r_s2;
  logic [N-1:0]   r_stable;
  logic [CW-1:0]  r_cnt [N];

  // Pending-event and sticky loss state
  logic [N-1:0]   r_pend;
  logic           r_lost;

  // Event FIFO
  logic [IDW-1:0] r_mem_id [FIFO_DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;

  // Combinational decisions
  logic [N-1:0]   w_diff;
  logic [N-1:0]   w_at_last;
  logic [N-1:0]   w_flip_on;
  logic [N-1:0]   w_rep_fire;
  logic [N-1:0]   w_set;
  logic [N-1:0]   w_keep;
  logic [N-1:0]   w_gnt;
  logic [IDW-1:0] w_gnt_idx;
  logic           w_full;
  logic           w_pop;
  logic           w_push;
  logic           w_lost_hit;

  // Out-of-range configurations elaborate a flagged, empty block so they
  // show up when browsing the elaborated hierarchy.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
      FIFO_DEPTH < 2) begin : g_cfg_out_of_range
  end

  // Per-button debounce decisions: disagreement, terminal count, press flip
  always_comb begin
    w_diff    = '0;
    w_at_last = '0;
    w_flip_on = '0;
    for (int i = 0; i < N; i++) begin
      w_diff[i]    = (~r_s2[i]) != r_stable[i];
      w_at_last[i] = (r_cnt[i] == c_DEB_LAST);
      w_flip_on[i] = w_diff[i] & w_at_last[i] & ~r_stable[i];
    end
  end

  // Two-flop synchronizer and per-button debounce counters
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_s1     <= '1;
      r_s2     <= '1;
      r_stable <= '0;
      for (int i = 0; i < N; i++) r_cnt[i] <= '0;
    end else begin
      r_s1 <= key_n;
      r_s2 <= r_s1;
      for (int i = 0; i < N; i++) begin
        if (w_diff[i]) begin
          if (w_at_last[i]) begin
            r_stable[i] <= ~r_stable[i];
            r_cnt[i]    <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + CW'(1);
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // Arbiter: lowest-index pending bit wins a FIFO slot; new sets beat grants
  always_comb begin
    w_gnt_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (r_pend[i]) w_gnt_idx = IDW'(i);
    end
    w_full     = (r_count == c_FULL);
    w_pop      = evt_valid & evt_ready;
    w_push     = (|r_pend) & (~w_full | w_pop);
    w_gnt      = w_push ? ({{(N-1){1'b0}}, 1'b1} << w_gnt_idx) : '0;
    w_keep     = r_pend & ~w_gnt;
    w_set      = w_flip_on | w_rep_fire;
    w_lost_hit = |(w_flip_on & w_keep);
  end

  // Pending bits and sticky lost flag
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pend <= '0;
      r_lost <= 1'b0;
    end else begin
      r_pend <= w_keep | w_set;
      r_lost <= r_lost | w_lost_hit;
    end
  end

  // FIFO pointers and occupancy; push+pop together leaves the count alone
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while empty since outputs are gated
  always_ff @(posedge Clk) begin
    if (w_push) r_mem_id[r_wr_ptr] <= w_gnt_idx;
  end

  assign pressed   = r_stable;
  assign evt_valid = (r_count != '0);
  assign evt_id    = evt_valid ? r_mem_id[r_rd_ptr] : '0;
  assign evt_lost  = r_lost;

`ifdef BTN_REPEAT_EN
  localparam logic [CW-1:0] c_RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] c_RP_LAST = CW'(REPEAT_PERIOD - 1);

  logic [CW-1:0]         r_rcnt [N];
  logic [N-1:0]          r_rphase;
  logic [N-1:0]          r_pend_rep;
  logic [N-1:0]          w_rep_nxt;
  logic [FIFO_DEPTH-1:0] r_mem_rep;

  // Repeat fire timing and repeat flag carried with each pending bit
  always_comb begin
    w_rep_fire = '0;
    w_rep_nxt  = '0;
    for (int i = 0; i < N; i++) begin
      w_rep_fire[i] = r_stable[i] &
                      (r_rcnt[i] == (r_rphase[i] ? c_RP_LAST : c_RD_LAST));
      if (w_flip_on[i])    w_rep_nxt[i] = 1'b0;
      else if (w_keep[i])  w_rep_nxt[i] = r_pend_rep[i];
      else                 w_rep_nxt[i] = w_rep_fire[i];
    end
  end

  // Repeat counters: run while held, first interval is the delay, then period
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rphase <= '0;
      for (int i = 0; i < N; i++) r_rcnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!r_stable[i]) begin
          r_rcnt[i]   <= '0;
          r_rphase[i] <= 1'b0;
        end else if (w_rep_fire[i]) begin
          r_rcnt[i]   <= '0;
          r_rphase[i] <= 1'b1;
        end else begin
          r_rcnt[i] <= r_rcnt[i] + CW'(1);
        end
      end
    end
  end

  // Repeat flag register alongside the pending bits
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_pend_rep <= '0;
    else          r_pend_rep <= w_rep_nxt;
  end

  // Repeat flag column of the FIFO
  always_ff @(posedge Clk) begin
    if (w_push) r_mem_rep[r_wr_ptr] <= r_pend_rep[w_gnt_idx];
  end

  assign evt_repeat = evt_valid & r_mem_rep[r_rd_ptr];
`else
  assign w_rep_fire = '0;
  assign evt_repeat = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_button_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_event_ctrl
// Purpose  : Directed bench for button_event_ctrl. Expected events are queued
//            as stimulus is applied; a monitor pops and compares every
//            accepted event. Level/flag outputs are checked in-line.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_event_ctrl;

  localparam int N   = 4;
  localparam int DEB = 4;
  localparam int CW  = 8;
  localparam int FD  = 2;
  localparam int RD  = 8;
  localparam int RP  = 4;

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic [N-1:0] key_n;
  logic [N-1:0] pressed;
  logic         evt_valid;
  logic [1:0]   evt_id;
  logic         evt_repeat;
  logic         evt_ready;
  logic         evt_lost;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [2:0] exp_q [$];

  button_event_ctrl #(
    .N(N), .DEBOUNCE_CYCLES(DEB), .CW(CW), .FIFO_DEPTH(FD),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .key_n(key_n), .pressed(pressed),
    .evt_valid(evt_valid), .evt_id(evt_id), .evt_repeat(evt_repeat),
    .evt_ready(evt_ready), .evt_lost(evt_lost)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Monitor: every accepted handshake must match the head of the queue
  always @(negedge Clk) begin : mon
    logic [2:0] e;
    if (Reset_n === 1'b1 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL unexpected_event: got id=%0d rep=%0b, expected none",
                 evt_id, evt_repeat);
      end else begin
        e = exp_q.pop_front();
        check("event{id,rep}", {29'd0, evt_id, evt_repeat}, {29'd0, e});
      end
    end
  end

  initial begin
    Reset_n   = 1'b0;
    key_n     = '1;
    evt_ready = 1'b0;
    step(3);
    check("rst_pressed", pressed, 0);
    check("rst_valid", evt_valid, 0);
    check("rst_id", evt_id, 0);
    check("rst_repeat", evt_repeat, 0);
    check("rst_lost", evt_lost, 0);
    #4 Reset_n = 1'b1;
    step(2);

    // Single press of button 1
    key_n = 4'b1101;
    exp_q.push_back({2'd1, 1'b0});
    step(5);
    check("single_pressed_early", pressed, 0);
    step(1);
    check("single_pressed", pressed, 4'b0010);
    check("single_valid_early", evt_valid, 0);
    step(1);
    check("single_valid_id", {evt_valid, evt_id}, {1'b1, 2'd1});
    evt_ready = 1'b1;
    step(1);
    check("single_popped", evt_valid, 0);
    evt_ready = 1'b0;
    key_n = '1;
    step(DEB + 2);
    check("single_released", pressed, 0);

    // Bounce shorter than the debounce window
    key_n = 4'b1110;
    step(3);
    key_n = '1;
    for (int k = 0; k < 10; k++) begin
      step(1);
      check("bounce_quiet", {pressed, evt_valid}, 0);
    end

    // All four buttons at once, drained continuously
    evt_ready = 1'b1;
    key_n = 4'b0000;
    for (int k = 0; k < 4; k++) exp_q.push_back({2'(k), 1'b0});
    step(6);
    check("simul_valid_early", evt_valid, 0);
    for (int k = 0; k < 4; k++) begin
      step(1);
      check("simul_order", {evt_valid, evt_id}, {1'b1, 2'(k)});
    end
    step(1);
    check("simul_empty", evt_valid, 0);
    check("simul_lost", evt_lost, 0);
    key_n = '1;
    step(DEB + 3);
    check("simul_released", pressed, 0);
    evt_ready = 1'b0;

    // Overflow: FIFO of 2 plus one pending, fourth press is lost
    for (int k = 0; k < 3; k++) begin
      key_n = 4'b0111;
      exp_q.push_back({2'd3, 1'b0});
      step(DEB + 3);
      key_n = '1;
      step(DEB + 3);
    end
    check("ovf_head", {evt_valid, evt_id}, {1'b1, 2'd3});
    check("ovf_not_lost", evt_lost, 0);
    key_n = 4'b0111;
    step(DEB + 3);
    check("ovf_lost", evt_lost, 1);
    key_n = '1;
    step(DEB + 3);
    evt_ready = 1'b1;
    step(5);
    check("ovf_drained", evt_valid, 0);
    check("ovf_lost_sticky", evt_lost, 1);
    evt_ready = 1'b0;

    // Reset while two events are queued
    key_n = 4'b1100;
    step(DEB + 4);
    check("rstmid_before", {evt_valid, evt_id, pressed}, {1'b1, 2'd0, 4'b0011});
    #3 Reset_n = 1'b0;
    #1;
    check("rstmid_valid", evt_valid, 0);
    check("rstmid_pressed", pressed, 0);
    check("rstmid_lost", evt_lost, 0);
    check("rstmid_id", evt_id, 0);
    key_n = '1;
    #3 Reset_n = 1'b1;
    step(DEB + 4);
    check("rstmid_after", {evt_valid, pressed}, 0);

    // Hold button 2: press event, plus auto-repeats when enabled
    evt_ready = 1'b1;
    key_n = 4'b1011;
    exp_q.push_back({2'd2, 1'b0});
`ifdef BTN_REPEAT_EN
    for (int k = 0; k < 3; k++) exp_q.push_back({2'd2, 1'b1});
`endif
    step(15);
`ifdef BTN_REPEAT_EN
    check("hold_first_repeat", {evt_valid, evt_id, evt_repeat}, {1'b1, 2'd2, 1'b1});
`else
    check("hold_no_repeat", {evt_valid, evt_id, evt_repeat}, 0);
`endif
    step(1);
    check("hold_repeat_popped", evt_valid, 0);
    step(2);
    key_n = '1;
    step(15);
    check("hold_released", {pressed, evt_valid}, 0);
    evt_ready = 1'b0;

    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
